dsp_addsub_pipe: RTL and testbench

Parametrised, fully pipelined integer adder/subtractor with per-operation add/sub select, chained carry-in, and carry/overflow flags. Operands are split into LANE-bit slices, one slice per pipeline stage, with the carry registered between stages, matching the 16-bit DSP-slice granularity. Valid/ready handshakes on both sides allow the ALU/execute path to stream one operation per cycle under back-pressure. Replaces the fixed 32-bit, sum-and-difference-in-parallel adder.

---
 rtl/dsp_addsub_pipe_pkg.sv | 12 +
 rtl/dsp_addsub_pipe_if.sv | 29 ++
 rtl/dsp_addsub_lane.sv | 41 ++++
 rtl/dsp_addsub_pipe.sv | 114 +++++++++++
 tb/tb_dsp_addsub_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_addsub_pipe_pkg.sv
// Shared encodings and default sizing for the pipelined adder/subtractor.
package dsp_addsub_pipe_pkg;

  // Native slice width of the DSP adder primitive.
  localparam int DSP_LANE_W = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/dsp_addsub_pipe_if.sv
// Valid/ready operation and result bus of dsp_addsub_pipe.
interface dsp_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_sub;
  logic             use_cin;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, a_in, b_in, op_sub, use_cin, cin, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  // The adder pipeline itself.
  modport slave (
    input  in_valid, a_in, b_in, op_sub, use_cin, cin, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/dsp_addsub_lane.sv
// One LANE-bit slice of the carry-pipelined adder: registered sum, carry
// and valid, all held while en is low.
module dsp_addsub_lane
  import dsp_addsub_pipe_pkg::*;
#(
  parameter int LANE = DSP_LANE_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            valid_in,
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic            cin,
  output logic            valid_q,
  output logic [LANE-1:0] sum_q,
  output logic            cout_q
);

  logic [LANE:0] sum_full;

  assign sum_full = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin};

  // Slice register: captures sum/carry/valid on advance, clears on reset.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the pipeline shifts by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset too (not just valid) because the
      // result and flags must read as zero straight out of reset.
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (en) begin
      valid_q <= valid_in;
      sum_q   <= sum_full[LANE-1:0];
      cout_q  <= sum_full[LANE];
    end
  end

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Fully pipelined WIDTH-bit add/sub: one LANE slice per stage, carry
// registered between stages, valid/ready on both sides.
module dsp_addsub_pipe
  import dsp_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = DSP_LANE_W
) (
  input  logic             clk,
  input  logic             reset,
  dsp_addsub_pipe_if.slave bus
);

  localparam int NLANES = WIDTH / LANE;

  if (WIDTH <= 0 || LANE <= 0 || (WIDTH % LANE) != 0) begin : g_bad_width
    $fatal(1, "dsp_addsub_pipe: WIDTH must be a positive multiple of LANE");
  end

  op_e              op;
  logic             advance;
  logic             load;
  logic             c0;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;

  // Per-stage operand skew and already-finished low result slices.
  logic [WIDTH-1:0] a_q       [NLANES];
  logic [WIDTH-1:0] b_q       [NLANES];
  logic [WIDTH-1:0] lo_q      [NLANES];
  logic [WIDTH-1:0] stage_res [NLANES];
  logic [LANE-1:0]  sum_q     [NLANES];
  logic             cout_q    [NLANES];
  logic             vld_q     [NLANES];

  assign op    = op_e'(bus.op_sub);
  assign b_eff = (op == OP_SUB) ? ~bus.b_in : bus.b_in;
  assign c0    = bus.use_cin ? bus.cin : (op == OP_SUB);

  // The whole pipe moves as one; only a held output blocks it.
  assign advance     = !vld_q[NLANES-1] || bus.out_ready;
  assign bus.in_ready = advance && !reset;
  assign load        = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [LANE-1:0] a_s;
    logic [LANE-1:0] b_s;
    logic            c_s;
    logic            v_s;

    if (k == 0) begin : g_first
      assign a_s = bus.a_in[LANE-1:0];
      assign b_s = b_eff[LANE-1:0];
      assign c_s = c0;
      assign v_s = load;
    end else begin : g_next
      assign a_s = a_q[k-1][k*LANE +: LANE];
      assign b_s = b_q[k-1][k*LANE +: LANE];
      assign c_s = cout_q[k-1];
      assign v_s = vld_q[k-1];
    end

    dsp_addsub_lane #(.LANE(LANE)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (advance),
      .valid_in (v_s),
      .a        (a_s),
      .b        (b_s),
      .cin      (c_s),
      .valid_q  (vld_q[k]),
      .sum_q    (sum_q[k]),
      .cout_q   (cout_q[k])
    );
  end

  // Operand skew: upper slices and finished low slices travel with the op.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NLANES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        lo_q[k] <= '0;
      end
    end else if (advance) begin
      a_q[0]  <= bus.a_in;
      b_q[0]  <= b_eff;
      lo_q[0] <= '0;
      for (int k = 1; k < NLANES; k++) begin
        a_q[k]  <= a_q[k-1];
        b_q[k]  <= b_q[k-1];
        lo_q[k] <= stage_res[k-1];
      end
    end
  end

  // Merge each stage's fresh slice onto the low slices it inherited.
  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      // NOTE: full default before the partial overwrite keeps this purely
      // combinational; a path that skips an assignment would infer a latch.
      stage_res[k] = lo_q[k];
      stage_res[k][k*LANE +: LANE] = sum_q[k];
    end
  end

  assign res           = stage_res[NLANES-1];
  assign bus.result    = res;
  assign bus.out_valid = vld_q[NLANES-1];
  assign bus.carry_out = cout_q[NLANES-1];
  assign bus.overflow  = (a_q[NLANES-1][WIDTH-1] == b_q[NLANES-1][WIDTH-1]) &&
                         (res[WIDTH-1] != a_q[NLANES-1][WIDTH-1]);

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Self-checking bench for dsp_addsub_pipe at WIDTH 32, 64 and 16.
module tb_dsp_addsub_pipe;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [63:0] res;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dsp_addsub_pipe_if #(.WIDTH(32)) bus32 ();
  dsp_addsub_pipe_if #(.WIDTH(64)) bus64 ();
  dsp_addsub_pipe_if #(.WIDTH(16)) bus16 ();

  dsp_addsub_pipe #(.WIDTH(32), .LANE(16)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  dsp_addsub_pipe #(.WIDTH(64), .LANE(16)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64));
  dsp_addsub_pipe #(.WIDTH(16), .LANE(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

  // Reference: plain unsigned sum for result/carry, true signed sum for overflow.
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic sub, input logic ucin, input logic cin);
    logic [63:0]        mask, am, be;
    logic               c0;
    logic [64:0]        u;
    logic signed [63:0] ta, tbv;
    logic signed [66:0] s, t;
    res_t               r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    be   = (sub ? ~b : b) & mask;
    c0   = ucin ? cin : sub;
    u    = {1'b0, am} + {1'b0, be} + {64'd0, c0};
    ta   = am << (64 - w);
    tbv  = be << (64 - w);
    s    = (ta >>> (64 - w)) + (tbv >>> (64 - w)) + $signed({66'd0, c0});
    t    = s >>> (w - 1);
    r.ovf  = (t != 67'sd0) && (t != -67'sd1);
    r.cout = u[w];
    r.res  = u[63:0] & mask;
    return r;
  endfunction

  task automatic idle32();
    bus32.in_valid  = 1'b0;
    bus32.a_in      = '0;
    bus32.b_in      = '0;
    bus32.op_sub    = 1'b0;
    bus32.use_cin   = 1'b0;
    bus32.cin       = 1'b0;
    bus32.out_ready = 1'b1;
  endtask

  task automatic drv(input int w, input logic v, input logic [63:0] a, input logic [63:0] b,
                     input logic sub, input logic uc, input logic ci, input logic ordy);
    if (w == 64) begin
      bus64.in_valid = v;  bus64.a_in = a;  bus64.b_in = b;
      bus64.op_sub = sub;  bus64.use_cin = uc;  bus64.cin = ci;  bus64.out_ready = ordy;
    end else begin
      bus16.in_valid = v;  bus16.a_in = a[15:0];  bus16.b_in = b[15:0];
      bus16.op_sub = sub;  bus16.use_cin = uc;  bus16.cin = ci;  bus16.out_ready = ordy;
    end
  endtask

  task automatic smp(input int w, output logic ir, output logic ov, output res_t r);
    if (w == 64) begin
      ir = bus64.in_ready;  ov = bus64.out_valid;
      r.res = bus64.result;  r.cout = bus64.carry_out;  r.ovf = bus64.overflow;
    end else begin
      ir = bus16.in_ready;  ov = bus16.out_valid;
      r.res = {48'd0, bus16.result};  r.cout = bus16.carry_out;  r.ovf = bus16.overflow;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus32.result); end
    checks++; if (bus32.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus32.carry_out); end
    checks++; if (bus32.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus32.overflow); end
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus32.in_ready); end
    checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid64: got %b want 0", bus64.out_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single op into an idle 32-bit pipe: latency, value, flags, single delivery.
  task automatic run_op32(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic uc, input logic ci,
                          input logic [31:0] exp_r, input logic exp_c, input logic exp_v);
    int lat;
    bit acc;
    @(negedge clk);
    bus32.in_valid = 1'b1;  bus32.a_in = a;  bus32.b_in = b;
    bus32.op_sub = sub;  bus32.use_cin = uc;  bus32.cin = ci;  bus32.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus32.in_ready === 1'b1) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!acc) begin errors++; $display("FAIL %s_accept: in_ready never rose", name); idle32(); return; end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      if (bus32.out_valid === 1'b1) begin lat = cyc; break; end
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
    checks++; if (bus32.result !== exp_r) begin errors++; $display("FAIL %s_result: got %h want %h", name, bus32.result, exp_r); end
    checks++; if (bus32.carry_out !== exp_c) begin errors++; $display("FAIL %s_carry: got %b want %b", name, bus32.carry_out, exp_c); end
    checks++; if (bus32.overflow !== exp_v) begin errors++; $display("FAIL %s_overflow: got %b want %b", name, bus32.overflow, exp_v); end
    @(negedge clk);
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL %s_once: out_valid got %b want 0", name, bus32.out_valid); end
  endtask

  task automatic test_arith();
    run_op32("add_carry_chain", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    run_op32("sub_zero_minus1", 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op32("sub_min_minus1",  32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op32("add_max_plus1",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op32("add_wrap",        32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op32("add_cin",         32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h00000003, 1'b0, 1'b0);
  endtask

  // Four back-to-back ops with out_ready dropped for three cycles mid-stream.
  task automatic test_back_to_back();
    logic [31:0] oa [4];
    logic [31:0] ob [4];
    logic        os [4];
    logic        ou [4];
    logic        oc [4];
    res_t        q [$];
    res_t        e;
    int          sent, got;
    logic        hold_v, hold_c, hold_o;
    logic [31:0] hold_r;
    for (int i = 0; i < 4; i++) begin
      oa[i] = $urandom;  ob[i] = $urandom;
      os[i] = 1'($urandom_range(0, 1));  ou[i] = 1'($urandom_range(0, 1));  oc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;  got = 0;  hold_v = 1'b0;  hold_c = 1'b0;  hold_o = 1'b0;  hold_r = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      bus32.in_valid = (sent < 4);
      if (sent < 4) begin
        bus32.a_in = oa[sent];  bus32.b_in = ob[sent];
        bus32.op_sub = os[sent];  bus32.use_cin = ou[sent];  bus32.cin = oc[sent];
      end
      bus32.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (!bus32.out_ready) begin
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_ready c%0d: out_valid=%b in_ready=%b want 1/0", c, bus32.out_valid, bus32.in_ready);
        end
        if (hold_v) begin
          checks++;
          if (bus32.result !== hold_r || bus32.carry_out !== hold_c || bus32.overflow !== hold_o) begin
            errors++; $display("FAIL stall_hold c%0d: got %h/%b/%b want %h/%b/%b", c,
                               bus32.result, bus32.carry_out, bus32.overflow, hold_r, hold_c, hold_o);
          end
        end
        hold_v = 1'b1;  hold_r = bus32.result;  hold_c = bus32.carry_out;  hold_o = bus32.overflow;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q.push_back(ref_model(32, {32'd0, oa[sent]}, {32'd0, ob[sent]}, os[sent], ou[sent], oc[sent]));
        sent++;
      end
      if (bus32.out_valid && bus32.out_ready) begin
        hold_v = 1'b0;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result %h", bus32.result);
        end else begin
          e = q.pop_front();
          if (bus32.result !== e.res[31:0] || bus32.carry_out !== e.cout || bus32.overflow !== e.ovf) begin
            errors++; $display("FAIL b2b_op%0d: got %h/%b/%b want %h/%b/%b", got,
                               bus32.result, bus32.carry_out, bus32.overflow, e.res[31:0], e.cout, e.ovf);
          end
        end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
    @(negedge clk);
    idle32();
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: out_valid got %b want 0", bus32.out_valid); end
  endtask

  // Reset one cycle after two accepts: both ops vanish, pipe restarts cleanly.
  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    bus32.in_valid = 1'b1;  bus32.a_in = 32'h11111111;  bus32.b_in = 32'h22222222;
    bus32.op_sub = 1'b0;  bus32.use_cin = 1'b0;  bus32.out_ready = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept0: in_ready got %b want 1", bus32.in_ready); end
    @(negedge clk);
    bus32.a_in = 32'h33333333;  bus32.b_in = 32'h44444444;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept1: in_ready got %b want 1", bus32.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    bus32.a_in = 32'h55555555;  bus32.b_in = 32'h66666666;
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", bus32.in_ready); end
    @(negedge clk);
    reset = 1'b0;
    idle32();
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus32.out_valid); end
    checks++;
    if (bus32.result !== 32'd0 || bus32.carry_out !== 1'b0 || bus32.overflow !== 1'b0) begin
      errors++; $display("FAIL rmid_cleared: got %h/%b/%b want 0/0/0", bus32.result, bus32.carry_out, bus32.overflow);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (bus32.out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rmid_ghost: flushed op reappeared"); end
    run_op32("after_reset", 32'h12345678, 32'h00000008, 1'b1, 1'b0, 1'b0, 32'h12345670, 1'b1, 1'b0);
  endtask

  task automatic test_latency(input int w);
    logic [63:0] a, b;
    logic        s, u, ci, ir, ov;
    res_t        e, r;
    int          lat;
    a = {$urandom, $urandom};  b = {$urandom, $urandom};
    s = 1'($urandom_range(0, 1));  u = 1'($urandom_range(0, 1));  ci = 1'($urandom_range(0, 1));
    e = ref_model(w, a, b, s, u, ci);
    @(negedge clk);
    drv(w, 1'b1, a, b, s, u, ci, 1'b1);
    #1;
    smp(w, ir, ov, r);
    checks++;
    if (ir !== 1'b1) begin errors++; $display("FAIL lat%0d_accept: in_ready got %b want 1", w, ir); drv(w, 1'b0, 0, 0, 0, 0, 0, 1'b1); return; end
    @(negedge clk);
    drv(w, 1'b0, a, b, s, u, ci, 1'b1);
    lat = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #1;
      smp(w, ir, ov, r);
      if (ov === 1'b1) begin lat = cyc; break; end
    end
    checks++; if (lat != w / 16) begin errors++; $display("FAIL lat%0d_latency: got %0d want %0d", w, lat, w / 16); end
    checks++;
    if (r !== e) begin errors++; $display("FAIL lat%0d_value: got %h/%b/%b want %h/%b/%b", w, r.res, r.cout, r.ovf, e.res, e.cout, e.ovf); end
  endtask

  // Random ops with random in_valid/out_ready against the reference queue.
  task automatic test_random(input int w, input int n);
    res_t        q [$];
    res_t        e, r;
    logic [63:0] ca, cb;
    logic        cs, cu, cc, v, ordy, ir, ov;
    int          sent, got, bad;
    sent = 0;  got = 0;  bad = 0;
    ca = {$urandom, $urandom};  cb = {$urandom, $urandom};
    cs = 1'($urandom_range(0, 1));  cu = 1'($urandom_range(0, 1));  cc = 1'($urandom_range(0, 1));
    for (int c = 0; c < 4 * n + 100 && got < n; c++) begin
      @(negedge clk);
      v    = (sent < n) && ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drv(w, v, ca, cb, cs, cu, cc, ordy);
      #1;
      smp(w, ir, ov, r);
      if (v && ir) begin
        q.push_back(ref_model(w, ca, cb, cs, cu, cc));
        sent++;
        ca = {$urandom, $urandom};  cb = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) cb = ~ca;
        cs = 1'($urandom_range(0, 1));  cu = 1'($urandom_range(0, 1));  cc = 1'($urandom_range(0, 1));
      end
      if (ov && ordy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand%0d_extra: unexpected result %h", w, r.res);
        end else begin
          e = q.pop_front();
          if (r !== e) begin
            errors++;
            if (bad < 10) $display("FAIL rand%0d_op%0d: got %h/%b/%b want %h/%b/%b", w, got, r.res, r.cout, r.ovf, e.res, e.cout, e.ovf);
            bad++;
          end
        end
        got++;
      end
    end
    @(negedge clk);
    drv(w, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    checks++;
    if (got != n || q.size() != 0) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d (pending %0d)", w, got, n, q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    idle32();
    drv(64, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    drv(16, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    test_latency(64);
    test_latency(16);
    test_random(64, 10000);
    test_random(16, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
